// File: rtl/page_multi_leaf_if_pkg.sv
// Shared types and constants for the multi-channel page leaf interface.
// The package name is referenced as page_if_pkg throughout the slice.
package page_if_pkg;

   localparam int PKT_W_DEF = 49;

   // Packet = {valid_flag, payload}; the page only ever sees the payload.
   function automatic int payload_w(input int pkt_w);
      return pkt_w - 1;
   endfunction

   typedef enum logic {
      WAIT_START = 1'b0,
      RUN        = 1'b1
   } chan_state_e;

endpackage

// File: rtl/page_multi_leaf_if_if.sv
// Bundle of the BFT-side and page-side signals for all NCH leaf channels.
// Channel c occupies slice [c*W +: W] of every multi-bit vector.
interface page_leaf_if
   import page_if_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int PKT_W = PKT_W_DEF
);

   localparam int PW = payload_w(PKT_W);

   logic [NCH*PKT_W-1:0] din_leaf_bft2interface;
   logic [NCH*PKT_W-1:0] dout_leaf_interface2bft;
   logic [NCH-1:0]       resend;
   logic [NCH-1:0]       ap_start;
   // Handshakes: a beat transfers on a cycle where valid && ready; the
   // producer holds data stable while valid && !ready, ready may be comb.
   logic [NCH*PW-1:0]    in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic [NCH*PW-1:0]    out_data;
   logic [NCH-1:0]       out_valid;
   logic [NCH-1:0]       out_ready;
   logic [NCH-1:0]       running;
   logic [NCH-1:0]       ovf;

   modport slave (
      input  din_leaf_bft2interface, resend, ap_start, in_ready, out_data, out_valid,
      output dout_leaf_interface2bft, in_data, in_valid, out_ready, running, ovf
   );

   modport master (
      output din_leaf_bft2interface, resend, ap_start, in_ready, out_data, out_valid,
      input  dout_leaf_interface2bft, in_data, in_valid, out_ready, running, ovf
   );

endinterface

// File: rtl/page_multi_leaf_if_leaf_chan_if.sv
// One leaf channel: start FSM, FWFT ingress FIFO with sticky overflow,
// and a registered egress path that can replay the last outbound packet.
module leaf_chan_if
   import page_if_pkg::*;
#(
   parameter int PKT_W = PKT_W_DEF,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PKT_W-1:0] din,
   output logic [PKT_W-1:0] dout,
   input  logic             resend,
   input  logic             ap_start,
   output logic [PKT_W-2:0] in_data,
   output logic             in_valid,
   input  logic             in_ready,
   input  logic [PKT_W-2:0] out_data,
   input  logic             out_valid,
   output logic             out_ready,
   output logic             running,
   output logic             ovf
);

   localparam int AW = $clog2(DEPTH);

   chan_state_e state, state_nxt;

   logic [PKT_W-2:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             full, empty, push_req, push, pop;

   logic [PKT_W-2:0] last_pkt;
   logic             has_sent;
   logic             accept, replay;

   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_START;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == WAIT_START && ap_start) state_nxt = RUN;
   end

   always_comb begin
      running   = (state == RUN);
      in_valid  = running && !empty;
      out_ready = running && !resend;
   end

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign push_req = din[PKT_W-1];
   assign pop      = in_valid && in_ready;
   // A full FIFO still takes a packet when a slot frees in the same cycle.
   assign push     = push_req && (!full || pop);
   assign in_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (push_req && !push) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din[PKT_W-2:0];
   end

   // out_ready drops while resend is high, so accept and replay never coincide.
   assign accept = out_valid && out_ready;
   assign replay = resend && has_sent;

   always_ff @(posedge clk) begin
      if (reset) begin
         dout     <= '0;
         last_pkt <= '0;
         has_sent <= 1'b0;
      end else if (accept) begin
         dout     <= {1'b1, out_data};
         last_pkt <= out_data;
         has_sent <= 1'b1;
      end else if (replay) begin
         dout     <= {1'b1, last_pkt};
      end else begin
         dout     <= '0;
      end
   end

endmodule

// File: rtl/page_multi_leaf_if.sv
// N-channel leaf interface for a reconfigurable page: one independent
// leaf_chan_if per BFT leaf link, sliced out of the shared bus vectors.
module page_multi_leaf_if
   import page_if_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int PKT_W = PKT_W_DEF,
   parameter int DEPTH = 16
) (
   input logic       clk,
   input logic       reset,
   page_leaf_if.slave bus
);

   localparam int PW = payload_w(PKT_W);

   logic [PKT_W-1:0] dout_c      [NCH];
   logic [PW-1:0]    in_data_c   [NCH];
   logic             in_valid_c  [NCH];
   logic             out_ready_c [NCH];
   logic             running_c   [NCH];
   logic             ovf_c       [NCH];

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      leaf_chan_if #(
         .PKT_W (PKT_W),
         .DEPTH (DEPTH)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .din       (bus.din_leaf_bft2interface[c*PKT_W +: PKT_W]),
         .dout      (dout_c[c]),
         .resend    (bus.resend[c]),
         .ap_start  (bus.ap_start[c]),
         .in_data   (in_data_c[c]),
         .in_valid  (in_valid_c[c]),
         .in_ready  (bus.in_ready[c]),
         .out_data  (bus.out_data[c*PW +: PW]),
         .out_valid (bus.out_valid[c]),
         .out_ready (out_ready_c[c]),
         .running   (running_c[c]),
         .ovf       (ovf_c[c])
      );
   end

   // Pack per-channel results so each bus vector has a single driver.
   always_comb begin
      bus.dout_leaf_interface2bft = '0;
      bus.in_data                 = '0;
      bus.in_valid                = '0;
      bus.out_ready               = '0;
      bus.running                 = '0;
      bus.ovf                     = '0;
      for (int c = 0; c < NCH; c++) begin
         bus.dout_leaf_interface2bft[c*PKT_W +: PKT_W] = dout_c[c];
         bus.in_data[c*PW +: PW]                       = in_data_c[c];
         bus.in_valid[c]                               = in_valid_c[c];
         bus.out_ready[c]                              = out_ready_c[c];
         bus.running[c]                                = running_c[c];
         bus.ovf[c]                                    = ovf_c[c];
      end
   end

endmodule

// File: doc/page_multi_leaf_if.md
Name: page_multi_leaf_if

Overview:
- Parametrised N-channel leaf interface for a reconfigurable page, generalising the two-slot double-page boundary.
- Each channel terminates one BFT leaf link:
  - ingress packets are buffered in a FIFO and streamed to page logic over valid/ready;
  - page-produced packets are registered onto the BFT;
  - a BFT resend request replays the last outbound packet.
- Per-channel ap_start gates page-side traffic.
- Sits between the BFT leaf ports and the HLS operator(s) inside the page.

Parameters:
- NCH, 2, number of leaf channels (1..8)
- PKT_W, 49, BFT packet width; bit PKT_W-1 is the valid flag, bits PKT_W-2:0 are the payload
- DEPTH, 16, ingress FIFO depth per channel; power of 2, at least 2

Ports:
- clk  in  1  single clock for all channels
- reset  in  1  synchronous, active-high; clears all state
- din_leaf_bft2interface  in  NCH*PKT_W  BFT-to-leaf packets; channel c occupies slice [c*PKT_W +: PKT_W]
- dout_leaf_interface2bft  out  NCH*PKT_W  leaf-to-BFT packets, same slicing
- resend  in  NCH  per-channel replay request from the BFT
- ap_start  in  NCH  per-channel start pulse
- in_data  out  NCH*(PKT_W-1)  ingress payload to page
- in_valid  out  NCH  ingress payload valid
- in_ready  in  NCH  page accepts ingress payload
- out_data  in  NCH*(PKT_W-1)  egress payload from page
- out_valid  in  NCH  egress payload valid
- out_ready  out  NCH  block accepts egress payload
- running  out  NCH  channel started
- ovf  out  NCH  sticky: ingress packet dropped because the FIFO was full

Behaviour:
- Reset values (every output): dout 0, in_valid 0, out_ready 0, running 0, ovf 0.
  - Reset also clears FIFO pointers and counts, the last-packet register and the has_sent flag.
  - Reset asserted mid-operation discards buffered packets within one cycle.
- Channels are fully independent. No cross-channel arbitration.
- Channel FSM, per channel:
  - States: WAIT_START, RUN.
  - WAIT_START -> RUN on ap_start=1. ap_start in RUN is ignored.
  - Only reset returns the channel to WAIT_START.
  - running = (state == RUN).
- Ingress:
  - When din[PKT_W-1]=1, the payload din[PKT_W-2:0] is pushed into the FIFO. Push happens in both states.
  - FIFO is first-word-fall-through.
  - A packet pushed at cycle t drives in_valid and in_data at t+1 at the earliest.
  - in_valid = running AND not empty. Pop occurs when in_valid AND in_ready.
  - Full FIFO with no pop that cycle: the arriving packet is dropped and ovf is set (sticky until reset).
  - Full FIFO with a pop in the same cycle: push and pop both succeed; count is unchanged.
  - Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Egress:
  - out_ready = running AND NOT resend (combinational).
  - Accept at cycle t (out_valid AND out_ready):
    - dout = {1'b1, out_data} at t+1, for exactly one cycle;
    - last_pkt <= out_data;
    - has_sent <= 1.
  - Resend at cycle t with has_sent=1: dout = {1'b1, last_pkt} at t+1.
  - Resend with has_sent=0: dout = 0.
  - Resend held for k cycles produces k consecutive replays.
  - Resend and out_valid in the same cycle: replay wins and nothing is accepted. out_ready=0 makes the page hold its data.
  - Resend is honoured in WAIT_START only if has_sent=1. In practice that cannot happen, because reset clears has_sent.
  - When there is no accept and no resend, dout = 0.
- Latency: ingress din to in_valid is 1 cycle; egress accept to dout is 1 cycle; resend to dout is 1 cycle.

Decomposition:
- Package page_if_pkg:
  - PKT_W_DEF = 49;
  - payload-width function;
  - channel state enum {WAIT_START, RUN}.
- Sub-module leaf_chan_if: one channel, containing the FSM, FIFO and egress/resend register.
- Top instantiates NCH copies in a generate loop and does the port slicing.

Test Plan:
- Gated ingress: NCH=2, DEPTH=4, no ap_start, send payloads 0x1, 0x2 on ch0 -> in_valid[0]=0. Pulse ap_start[0] -> in_data 0x1 then 0x2 on consecutive cycles with in_ready=1. ch1 in_valid stays 0.
- Overflow: hold in_ready=0, send 5 packets 0xA..0xE on ch0 -> ovf[0]=1 after the 5th. Draining yields exactly 0xA..0xD. ovf stays 1.
- Full with simultaneous push and pop: FIFO full, push 0xF and pop in the same cycle -> ovf unchanged; 0xF is delivered last.
- Egress and resend: accept 0x123 on ch1, then resend[1]=1 for 2 cycles -> dout ch1 = {1,0x123} at accept+1, then valid replays of 0x123 at the next two resend+1 cycles. out_ready[1]=0 while resend is high.
- Resend before any send: after ap_start, assert resend[0] -> dout ch0 stays 0.
- Reset mid-operation: FIFO holds 3 packets and ch0 is running; assert reset 1 cycle -> all outputs 0, running=0. A subsequent ap_start shows an empty FIFO.
